// File: rtl/uart_rx_fifo_if.sv
// Interface between the UART receive buffer and its neighbours.
// It carries the receiver side (rx_data, rx_data_valid, parity_error) and the
// reader side (rd_en, flush, clr_overrun, rd_data, rd_parity_err, status).
// The master modport is used by whoever drives the buffer.
// The slave modport is used by uart_rx_fifo itself.
interface uart_rx_fifo_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
);
  logic [DATA_W-1:0]        rx_data;
  logic                     rx_data_valid;
  logic                     parity_error;
  logic                     rd_en;
  logic                     flush;
  logic                     clr_overrun;
  logic [DATA_W-1:0]        rd_data;
  logic                     rd_parity_err;
  logic                     empty;
  logic                     full;
  logic [$clog2(DEPTH):0]   count;
  logic                     overrun;
  logic                     irq_thresh;

  modport master (
    output rx_data, rx_data_valid, parity_error, rd_en, flush, clr_overrun,
    input  rd_data, rd_parity_err, empty, full, count, overrun, irq_thresh
  );

  modport slave (
    input  rx_data, rx_data_valid, parity_error, rd_en, flush, clr_overrun,
    output rd_data, rd_parity_err, empty, full, count, overrun, irq_thresh
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver.
// Each rising edge of rx_data_valid captures {parity_error, rx_data} into a
// first-word-fall-through FIFO. The buffer reports its fill level, a sticky
// overrun flag and a threshold interrupt.
// Ports:
//   clk, rst_n : system clock and asynchronous active-low reset
//   bus        : uart_rx_fifo_if.slave
//                - receiver inputs: rx_data, rx_data_valid, parity_error
//                - reader controls: rd_en, flush, clr_overrun
//                - outputs: rd_data, rd_parity_err, empty, full, count,
//                  overrun, irq_thresh
module uart_rx_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned THRESH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_rx_fifo_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W:0]  mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             valid_q;
  logic             ovr;

  logic             wr_edge;
  logic             is_empty;
  logic             is_full;
  logic             rd_ok;
  logic             wr_ok;
  logic             ovr_set;
  logic [DATA_W:0]  head;

  assign wr_edge  = bus.rx_data_valid & ~valid_q;
  assign is_empty = (cnt == '0);
  assign is_full  = (cnt == CW'(DEPTH));
  // A flush discards any read or write edge that falls in the same cycle.
  assign rd_ok    = bus.rd_en & ~is_empty & ~bus.flush;
  // When the FIFO is full, a concurrent pop frees the slot the write needs.
  assign wr_ok    = wr_edge & ~bus.flush & (~is_full | rd_ok);
  assign ovr_set  = wr_edge & ~bus.flush & is_full & ~rd_ok;

  // The edge detector keeps tracking through a flush, so a valid signal held
  // across the flush does not re-trigger a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      ovr     <= 1'b0;
    end else begin
      valid_q <= bus.rx_data_valid;
      if (ovr_set)
        ovr <= 1'b1;
      else if (bus.clr_overrun)
        ovr <= 1'b0;
      if (bus.flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
        if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
        unique case ({wr_ok, rd_ok})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: cnt <= cnt;
        endcase
      end
    end
  end

  // Storage has no reset; the pointers and the count define which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[wr_ptr] <= {bus.parity_error, bus.rx_data};
  end

  assign head              = mem[rd_ptr];
  assign bus.rd_data       = is_empty ? '0 : head[DATA_W-1:0];
  assign bus.rd_parity_err = is_empty ? 1'b0 : head[DATA_W];
  assign bus.empty         = is_empty;
  assign bus.full          = is_full;
  assign bus.count         = cnt;
  assign bus.overrun       = ovr;
  assign bus.irq_thresh    = (cnt >= CW'(THRESH));
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed testbench for uart_rx_fifo (DATA_W=8, DEPTH=16, THRESH=8).
module tb_uart_rx_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned checks = 0;
  int unsigned passes = 0;

  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DATA_W(8), .DEPTH(16)) bus ();

  uart_rx_fifo #(.DATA_W(8), .DEPTH(16), .THRESH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write one character: valid high for one cycle, then low for one cycle.
  task automatic write_char(input logic [7:0] d, input logic p);
    bus.rx_data       = d;
    bus.parity_error  = p;
    bus.rx_data_valid = 1'b1;
    tick();
    bus.rx_data_valid = 1'b0;
    tick();
  endtask

  task automatic pop();
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
  endtask

  initial begin
    bus.rx_data       = '0;
    bus.rx_data_valid = 1'b0;
    bus.parity_error  = 1'b0;
    bus.rd_en         = 1'b0;
    bus.flush         = 1'b0;
    bus.clr_overrun   = 1'b0;
    #12;
    check("rst_empty",   bus.empty, 1);
    check("rst_full",    bus.full, 0);
    check("rst_count",   bus.count, 0);
    check("rst_overrun", bus.overrun, 0);
    check("rst_irq",     bus.irq_thresh, 0);
    check("rst_rd_data", bus.rd_data, 0);
    rst_n = 1'b1;
    tick();

    // 1: single pulse, then pop
    bus.rx_data = 8'h41; bus.parity_error = 1'b0; bus.rx_data_valid = 1'b1;
    tick();
    bus.rx_data_valid = 1'b0;
    check("t1_empty", bus.empty, 0);
    check("t1_count", bus.count, 1);
    check("t1_data",  bus.rd_data, 8'h41);
    pop();
    check("t1_pop_empty", bus.empty, 1);
    check("t1_pop_count", bus.count, 0);

    // 2: valid held for 5 cycles gives exactly one write
    bus.rx_data = 8'h55; bus.rx_data_valid = 1'b1;
    repeat (5) tick();
    bus.rx_data_valid = 1'b0;
    tick();
    check("t2_count", bus.count, 1);
    check("t2_data",  bus.rd_data, 8'h55);
    pop();
    check("t2_drain", bus.count, 0);

    // 3: fill, overrun, set-over-clear, in-order drain
    for (int i = 0; i < 16; i++) write_char(8'(i), 1'b0);
    check("t3_full",     bus.full, 1);
    check("t3_count16",  bus.count, 16);
    check("t3_no_ovr",   bus.overrun, 0);
    write_char(8'hAA, 1'b0);
    check("t3_ovr",      bus.overrun, 1);
    check("t3_count_ov", bus.count, 16);
    check("t3_head",     bus.rd_data, 8'h00);
    bus.rx_data = 8'hBB; bus.rx_data_valid = 1'b1; bus.clr_overrun = 1'b1;
    tick();
    bus.rx_data_valid = 1'b0; bus.clr_overrun = 1'b0;
    check("t3_set_wins", bus.overrun, 1);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t3_rd%0d", i), bus.rd_data, i);
      pop();
    end
    check("t3_empty",     bus.empty, 1);
    check("t3_ovr_stays", bus.overrun, 1);
    bus.clr_overrun = 1'b1;
    tick();
    bus.clr_overrun = 1'b0;
    check("t3_ovr_clr", bus.overrun, 0);

    // 4: write plus read while full
    for (int i = 0; i < 16; i++) write_char(8'(8'h20 + i), 1'b0);
    bus.rx_data = 8'h99; bus.rx_data_valid = 1'b1; bus.rd_en = 1'b1;
    tick();
    bus.rx_data_valid = 1'b0; bus.rd_en = 1'b0;
    check("t4_count",  bus.count, 16);
    check("t4_no_ovr", bus.overrun, 0);
    for (int i = 1; i < 16; i++) begin
      check($sformatf("t4_rd%0d", i), bus.rd_data, 8'h20 + i);
      pop();
    end
    check("t4_last", bus.rd_data, 8'h99);
    pop();
    check("t4_empty", bus.empty, 1);

    // 5: parity flag travels with its character
    write_char(8'h12, 1'b1);
    write_char(8'h34, 1'b0);
    check("t5_perr1", bus.rd_parity_err, 1);
    check("t5_data1", bus.rd_data, 8'h12);
    pop();
    check("t5_perr2", bus.rd_parity_err, 0);
    check("t5_data2", bus.rd_data, 8'h34);
    pop();

    // write plus read while empty: the write wins and the read is ignored
    bus.rx_data = 8'h5A; bus.rx_data_valid = 1'b1; bus.rd_en = 1'b1;
    tick();
    bus.rx_data_valid = 1'b0; bus.rd_en = 1'b0;
    check("we_count", bus.count, 1);
    check("we_data",  bus.rd_data, 8'h5A);
    pop();

    // 6: threshold, flush, empty read, async reset
    for (int i = 0; i < 7; i++) write_char(8'(i), 1'b0);
    check("t6_irq_below", bus.irq_thresh, 0);
    write_char(8'h07, 1'b0);
    check("t6_irq",   bus.irq_thresh, 1);
    check("t6_cnt8",  bus.count, 8);
    bus.flush = 1'b1; bus.rx_data = 8'h77; bus.rx_data_valid = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("t6_flush_cnt", bus.count, 0);
    check("t6_flush_irq", bus.irq_thresh, 0);
    check("t6_flush_emp", bus.empty, 1);
    tick();
    bus.rx_data_valid = 1'b0;
    check("t6_no_retrig", bus.count, 0);
    pop();
    check("t6_underflow", bus.count, 0);
    check("t6_uf_empty",  bus.empty, 1);
    write_char(8'hC3, 1'b1);
    write_char(8'h3C, 1'b0);
    check("t6_pre_rst", bus.count, 2);
    #2 rst_n = 1'b0;
    #1;
    check("t6_arst_cnt",   bus.count, 0);
    check("t6_arst_empty", bus.empty, 1);
    check("t6_arst_data",  bus.rd_data, 0);
    check("t6_arst_perr",  bus.rd_parity_err, 0);
    #3 rst_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive buffer directly downstream of the UART receiver. It captures each received character and its parity-error flag when the receiver reports a completed frame. It stores them in a first-word-fall-through FIFO for the CPU-side reader and reports fill level, overrun and a threshold interrupt. This decouples the bit-rate receiver from bus read latency.

Parameters:
DATA_W, 8, character width; must match the receiver's data word.
DEPTH, 16, FIFO entries; power of two, minimum 2.
THRESH, 8, fill level at or above which irq_thresh asserts; range 1..DEPTH.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, active-low, asynchronous
rx_data  in  DATA_W  character from the receiver
rx_data_valid  in  1  receiver frame-done indication; may be held high for more than one cycle
parity_error  in  1  parity flag for the character on rx_data; sampled with it
rd_en  in  1  reader pops the head entry this cycle
flush  in  1  synchronous clear of the FIFO contents
clr_overrun  in  1  clears the sticky overrun flag
rd_data  out  DATA_W  head entry character (FWFT)
rd_parity_err  out  1  head entry parity flag
empty  out  1  no entries stored
full  out  1  DEPTH entries stored
count  out  $clog2(DEPTH)+1  current number of entries
overrun  out  1  sticky flag: a character was dropped because the FIFO was full
irq_thresh  out  1  count >= THRESH

Behaviour:
- Reset (async, rst_n low): wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, overrun=0, irq_thresh=0, valid-edge register=0. rd_data and rd_parity_err are 0 while empty.
- Write event: a rising edge of rx_data_valid, detected with a one-flop delay register (valid & ~valid_q). Exactly one write occurs per high period, however long. rx_data and parity_error are sampled in the edge cycle.
- Storage: entry = {parity_error, rx_data}. On an accepted write, the entry is written at wr_ptr and wr_ptr increments modulo DEPTH.
- Read: rd_en while !empty pops the head; rd_ptr increments modulo DEPTH. rd_en while empty is ignored, with no pointer change and no error flag.
- FWFT: when !empty, rd_data and rd_parity_err show mem[rd_ptr] combinationally from the registered pointer. A written entry becomes visible the cycle after its write edge.
- count: +1 on accepted write only, -1 on accepted read only, unchanged on both or neither. empty = (count==0), full = (count==DEPTH), irq_thresh = (count>=THRESH). All are derived from the registered count.
- Simultaneous write and read when full: the read pops and the write is accepted. count stays DEPTH and overrun is not set.
- Simultaneous write and read when empty: the write is accepted and the read is ignored, so count becomes 1.
- Write while full without a read: the character is dropped, memory and pointers are unchanged, and overrun is set the next cycle.
- overrun is sticky. clr_overrun clears it. If clr_overrun and a new overrun occur in the same cycle, set wins.
- flush: next cycle, pointers=0, count=0, empty=1. A write edge or read in the flush cycle is discarded. overrun is unaffected. The edge-detect register still updates, so a valid held across the flush does not re-trigger.
- Reset mid-operation clears all state immediately. Contents are lost and need not be cleared in memory.
- No latency from the read request: rd_en pops in the same cycle, and the next head is visible the following cycle.

Test Plan:
1. Reset, then one pulse with rx_data=0x41, parity_error=0 -> next cycle empty=0, count=1, rd_data=0x41. Then rd_en for 1 cycle -> empty=1, count=0.
2. rx_data_valid held high 5 cycles with rx_data=0x55 -> exactly one entry, count=1.
3. 16 writes of 0x00..0x0F, then a 17th write of 0xAA -> full=1, count=16, overrun=1. Reading 16 times returns 0x00..0x0F in order, 0xAA is never returned, and overrun stays 1 until clr_overrun.
4. Fill to 16, then a write edge with rd_en in the same cycle (data 0x99) -> count=16, overrun=0. The last of 16 further reads returns 0x99.
5. Write 0x12 with parity_error=1, then 0x34 with parity_error=0 -> rd_parity_err=1 with rd_data=0x12. After the pop, rd_parity_err=0 with rd_data=0x34.
6. Write 8 entries -> irq_thresh=1 at count=8. Then flush -> count=0, irq_thresh=0. rd_en on empty leaves count=0 with no underflow. Deasserting rst_n mid-stream resets all outputs asynchronously.
